running_max: RTL and testbench



---
 rtl/running_max.sv | 72 +++++++
 tb/tb_running_max.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/running_max.sv
// Streaming running-maximum tracker.
// Holds the largest sample accepted since reset or clear, with a flag that
// says whether any sample has been accepted yet and a pulse when the held
// maximum changes. All outputs are registered.
module running_max #(
  parameter int unsigned WIDTH  = 32,
  // 0: unsigned magnitude compare, 1: two's-complement compare
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,      // synchronous, active-low
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             upd
);

  logic [WIDTH-1:0] y_d, y_q;
  logic             valid_d, valid_q;
  logic             upd_d, upd_q;
  logic             x_gt_y;

  // Strict greater-than in the selected number representation.
  always_comb begin
    if (SIGNED) begin
      x_gt_y = $signed(x) > $signed(y_q);
    end else begin
      x_gt_y = x > y_q;
    end
  end

  // Next state: clear beats enable; x is only consulted when en is high.
  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
    upd_d   = 1'b0;
    if (clr) begin
      y_d     = '0;
      valid_d = 1'b0;
    end else if (en) begin
      if (!valid_q) begin
        // First sample always loads, whatever its value.
        y_d     = x;
        valid_d = 1'b1;
        upd_d   = 1'b1;
      end else if (x_gt_y) begin
        y_d   = x;
        upd_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
    end
  end

  assign y       = y_q;
  assign y_valid = valid_q;
  assign upd     = upd_q;

endmodule

// File: tb/tb_running_max.sv
// Bench for running_max: an unsigned and a signed instance share one stimulus
// stream. A reference model keeps the list of accepted samples and derives the
// expected outputs from it; a separate monitor compares every cycle.
module tb_running_max;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] x   = '0;

  logic [W-1:0] y_u, y_s;
  logic         v_u, v_s, u_u, u_s;

  running_max #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
    .y(y_u), .y_valid(v_u), .upd(u_u)
  );

  running_max #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
    .y(y_s), .y_valid(v_s), .upd(u_s)
  );

  typedef struct packed {
    logic [W-1:0] y;
    logic         v;
    logic         u;
  } exp_t;

  exp_t         q_u[$];
  exp_t         q_s[$];
  logic [W-1:0] acc[$];   // samples accepted since last reset/clear
  int           tests = 0;
  int           fails = 0;

  // Maximum of all accepted samples under the chosen ordering.
  function automatic logic [W-1:0] max_of(input bit sgn);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < acc.size(); i++) begin
      if (i == 0) m = acc[i];
      else if (sgn ? ($signed(acc[i]) > $signed(m)) : (acc[i] > m)) m = acc[i];
    end
    return m;
  endfunction

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's expected result for each instance.
  task automatic step(input logic r, input logic c, input logic e, input logic [W-1:0] d);
    exp_t         eu, es;
    logic [W-1:0] pu, ps;
    bit           had, acc_now;
    @(negedge clk);
    rst = r; clr = c; en = e; x = d;
    had     = acc.size() != 0;
    pu      = max_of(1'b0);
    ps      = max_of(1'b1);
    acc_now = r && !c && e;
    if (!r || c) acc.delete();
    else if (e) acc.push_back(d);
    eu.v = acc.size() != 0;
    es.v = eu.v;
    eu.y = max_of(1'b0);
    es.y = max_of(1'b1);
    // A pulse means the held value moved, or the very first sample loaded.
    eu.u = acc_now && (!had || eu.y != pu);
    es.u = acc_now && (!had || es.y != ps);
    q_u.push_back(eu);
    q_s.push_back(es);
  endtask

  // Monitor: outputs are registered, so one result per edge after each step.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_u.size() != 0) begin
      e = q_u.pop_front();
      cmp("u.y", y_u, e.y);
      cmp("u.y_valid", {{(W-1){1'b0}}, v_u}, {{(W-1){1'b0}}, e.v});
      cmp("u.upd", {{(W-1){1'b0}}, u_u}, {{(W-1){1'b0}}, e.u});
    end
    if (q_s.size() != 0) begin
      e = q_s.pop_front();
      cmp("s.y", y_s, e.y);
      cmp("s.y_valid", {{(W-1){1'b0}}, v_s}, {{(W-1){1'b0}}, e.v});
      cmp("s.upd", {{(W-1){1'b0}}, u_s}, {{(W-1){1'b0}}, e.u});
    end
  end

  logic [W-1:0] useq[7];

  initial begin
    useq[0] = 32'd5;  useq[1] = 32'd3;  useq[2] = 32'd9; useq[3] = 32'd9;
    useq[4] = 32'd2;  useq[5] = 32'hFFFF_FFFF;            useq[6] = 32'd7;

    // Reset for two edges, then idle with en low.
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'(i * 17));
    // x undriven while en is low must not matter.
    step(1'b1, 1'b0, 1'b0, 'x);

    // Unsigned sequence; signed instance sees the same stream.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, useq[i]);
    @(negedge clk);
    cmp("seq.final_u", y_u, 32'hFFFF_FFFF);
    cmp("seq.final_s", y_s, 32'd9);

    // Signed sequence after a fresh reset.
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF6);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFEC);
    step(1'b1, 1'b0, 1'b1, 32'd4);
    step(1'b1, 1'b0, 1'b1, 32'h8000_0000);
    @(negedge clk);
    cmp("sgn.final_s", y_s, 32'd4);
    cmp("sgn.final_u", y_u, 32'hFFFF_FFF6);

    // Enable gating from y=9.
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'd9);
    step(1'b1, 1'b0, 1'b0, 32'd100);
    step(1'b1, 1'b0, 1'b1, 32'd100);

    // Clear drops the same-cycle sample; reset beats enable.
    step(1'b1, 1'b1, 1'b1, 32'd50);
    step(1'b1, 1'b0, 1'b1, 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'd500);
    step(1'b1, 1'b0, 1'b1, 32'd0);   // first sample of zero still pulses upd
    step(1'b1, 1'b0, 1'b1, 32'd0);   // equal value never pulses

    // Random soak, en always high.
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b1, $urandom);
    // Mixed traffic with occasional clear and reset.
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom);
    end

    // Drain: every pushed expectation must have been consumed.
    repeat (3) @(negedge clk);
    cmp("drain.q_u", 32'(q_u.size()), 32'd0);
    cmp("drain.q_s", 32'(q_s.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
